// File: rtl/rob.sv
// Reorder buffer: allocates rob ids in program order, collects ALU/LSB completion
// broadcasts, answers operand queries and retires in order, flushing on mispredict.
module rob #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic [ROB_WIDTH-1:0] alloc_id,
  input  logic                 dec_ready,
  input  logic [1:0]           dec_kind,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_pred_pc,
  input  logic [ROB_WIDTH-1:0] qry_j_id,
  input  logic [ROB_WIDTH-1:0] qry_k_id,
  output logic                 qry_j_ready,
  output logic                 qry_k_ready,
  output logic [31:0]          qry_j_value,
  output logic [31:0]          qry_k_value,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 store_commit,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;

  logic        e_busy  [ROB_SIZE];
  logic        e_ready [ROB_SIZE];
  logic [1:0]  e_kind  [ROB_SIZE];
  logic [4:0]  e_rd    [ROB_SIZE];
  logic [31:0] e_value [ROB_SIZE];
  logic [31:0] e_pred  [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;

  logic head_commit;
  logic mispredict;
  logic do_alloc;

  // Handshakes: dec_ready is a one-cycle request taken only when !rob_full, no flush
  // is in progress and rdy_in is high; broadcasts are one-cycle valid strobes with
  // no backpressure; commit/store_commit/clear are one-cycle pulses.
  assign rob_full  = (count == CNT_FULL);
  assign rob_empty = (count == '0);
  assign alloc_id  = tail;

  always_comb begin
    head_commit = e_busy[head] && e_ready[head];
    mispredict  = head_commit && (e_kind[head] == KIND_BRANCH) &&
                  (e_value[head] != e_pred[head]);
    // Drop allocation both on the mispredict edge and while the flush pulse is out.
    do_alloc    = dec_ready && !rob_full && !clear && !mispredict;
  end

  // Broadcasts bypass storage so a dependent issued this cycle sees the value.
  always_comb begin
    qry_j_ready = e_busy[qry_j_id] && e_ready[qry_j_id];
    qry_j_value = e_value[qry_j_id];
    if (rs_ready && (rs_rob_id == qry_j_id)) begin
      qry_j_ready = 1'b1;
      qry_j_value = rs_value;
    end
    if (lsb_ready && (lsb_rob_id == qry_j_id)) begin
      qry_j_ready = 1'b1;
      qry_j_value = lsb_value;
    end
  end

  always_comb begin
    qry_k_ready = e_busy[qry_k_id] && e_ready[qry_k_id];
    qry_k_value = e_value[qry_k_id];
    if (rs_ready && (rs_rob_id == qry_k_id)) begin
      qry_k_ready = 1'b1;
      qry_k_value = rs_value;
    end
    if (lsb_ready && (lsb_rob_id == qry_k_id)) begin
      qry_k_ready = 1'b1;
      qry_k_value = lsb_value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        e_busy[i]  <= 1'b0;
        e_ready[i] <= 1'b0;
        e_kind[i]  <= '0;
        e_rd[i]    <= '0;
        e_value[i] <= '0;
        e_pred[i]  <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      store_commit  <= 1'b0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else if (!rdy_in) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      clear        <= 1'b0;
    end else begin
      commit_valid <= head_commit;
      store_commit <= head_commit && (e_kind[head] == KIND_STORE);
      clear        <= mispredict;
      if (head_commit) begin
        commit_rob_id <= head;
        commit_rd     <= (e_kind[head] == KIND_REG) ? e_rd[head] : 5'd0;
        commit_value  <= e_value[head];
      end
      if (mispredict) clear_pc <= e_value[head];

      if (do_alloc) begin
        e_busy[tail]  <= 1'b1;
        e_ready[tail] <= 1'b0;
        e_kind[tail]  <= dec_kind;
        e_rd[tail]    <= dec_rd;
        e_pred[tail]  <= dec_pred_pc;
        tail          <= tail + PTR_ONE;
      end

      // lsb is written last so it wins a same-id collision with rs.
      if (rs_ready && e_busy[rs_rob_id] && !e_ready[rs_rob_id]) begin
        e_value[rs_rob_id] <= rs_value;
        e_ready[rs_rob_id] <= 1'b1;
      end
      if (lsb_ready && e_busy[lsb_rob_id] && !e_ready[lsb_rob_id]) begin
        e_value[lsb_rob_id] <= lsb_value;
        e_ready[lsb_rob_id] <= 1'b1;
      end

      if (head_commit) begin
        e_busy[head]  <= 1'b0;
        e_ready[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end

      if (mispredict) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          e_busy[i]  <= 1'b0;
          e_ready[i] <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (do_alloc && !head_commit) begin
        count <= count + CNT_ONE;
      end else if (head_commit && !do_alloc) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: in-order retire, bypass queries, mispredict flush,
// pointer wrap and asynchronous reset; retires are checked against a queue.
module tb_rob;

  localparam int W  = 3;
  localparam int RW = 2 + W + 5 + 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_full, rob_empty;
  logic [W-1:0]  alloc_id;
  logic          dec_ready;
  logic [1:0]    dec_kind;
  logic [4:0]    dec_rd;
  logic [31:0]   dec_pred_pc;
  logic [W-1:0]  qry_j_id, qry_k_id;
  logic          qry_j_ready, qry_k_ready;
  logic [31:0]   qry_j_value, qry_k_value;
  logic          rs_ready;
  logic [W-1:0]  rs_rob_id;
  logic [31:0]   rs_value;
  logic          lsb_ready;
  logic [W-1:0]  lsb_rob_id;
  logic [31:0]   lsb_value;
  logic          commit_valid;
  logic [W-1:0]  commit_rob_id;
  logic [4:0]    commit_rd;
  logic [31:0]   commit_value;
  logic          store_commit, clear;
  logic [31:0]   clear_pc;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  rob #(.ROB_WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rob_empty(rob_empty), .alloc_id(alloc_id),
    .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc),
    .qry_j_id(qry_j_id), .qry_k_id(qry_k_id),
    .qry_j_ready(qry_j_ready), .qry_k_ready(qry_k_ready),
    .qry_j_value(qry_j_value), .qry_k_value(qry_k_value),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_value(commit_value), .store_commit(store_commit),
    .clear(clear), .clear_pc(clear_pc)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic c, input logic s, input int id,
                                        input int rd, input logic [31:0] v);
    return {c, s, W'(id), 5'(rd), v};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dec_ready = 1'b0; dec_kind = 2'd0; dec_rd = 5'd0; dec_pred_pc = 32'd0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = 32'd0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = 32'd0;
  endtask

  task automatic alloc(input logic [1:0] kind, input int rd, input logic [31:0] pred);
    dec_ready = 1'b1; dec_kind = kind; dec_rd = 5'(rd); dec_pred_pc = pred;
  endtask

  // scoreboard: every retire pulse is popped and compared
  always @(posedge clk_in) begin
    #1;
    if (commit_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL commit_unexpected observed id=%0d expected no commit", commit_rob_id);
      end
      if (exp_q.size() != 0)
        chk("commit_rec", 64'({clear, store_commit, commit_rob_id, commit_rd, commit_value}),
            64'(exp_q.pop_front()));
    end else begin
      chk("idle_pulses", {62'd0, store_commit, clear}, 64'd0);
    end
  end

  initial begin
    logic [W-1:0] d;
    int b;
    idle();
    qry_j_id = '0; qry_k_id = '0;
    rdy_in = 1'b1;
    rst_in = 1'b0;
    #2;
    chk("rst_empty", 64'(rob_empty), 64'd1);
    chk("rst_full", 64'(rob_full), 64'd0);
    chk("rst_alloc_id", 64'(alloc_id), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    #10;
    rst_in = 1'b1;
    step();

    // fill all eight entries, then a ninth request is ignored
    for (int i = 0; i < 8; i++) begin
      chk("fill_alloc_id", 64'(alloc_id), 64'(i));
      alloc(2'd0, i + 1, 32'd0);
      step();
    end
    chk("fill_full", 64'(rob_full), 64'd1);
    chk("fill_not_empty", 64'(rob_empty), 64'd0);
    step();
    chk("ninth_alloc_id", 64'(alloc_id), 64'd0);
    chk("ninth_full", 64'(rob_full), 64'd1);
    idle();

    // out-of-order completion, in-order retire
    rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'h22;
    step();
    idle();
    step();
    chk("no_commit_before_head", 64'(commit_valid), 64'd0);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h10;
    lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h11;
    exp_q.push_back(rec(0, 0, 0, 1, 32'h10));
    exp_q.push_back(rec(0, 0, 1, 2, 32'h11));
    exp_q.push_back(rec(0, 0, 2, 3, 32'h22));
    step();
    idle();
    repeat (4) step();
    chk("after3_full", 64'(rob_full), 64'd0);

    // operand queries with same-cycle broadcast bypass
    qry_j_id = 3'd3; qry_k_id = 3'd4;
    #1;
    chk("qry_j_not_ready", 64'(qry_j_ready), 64'd0);
    rs_ready = 1'b1; rs_rob_id = 3'd3; rs_value = 32'hAB;
    lsb_ready = 1'b1; lsb_rob_id = 3'd4; lsb_value = 32'h44;
    #1;
    chk("qry_j_bypass_ready", 64'(qry_j_ready), 64'd1);
    chk("qry_j_bypass_value", 64'(qry_j_value), 64'hAB);
    chk("qry_k_bypass_ready", 64'(qry_k_ready), 64'd1);
    chk("qry_k_bypass_value", 64'(qry_k_value), 64'h44);
    exp_q.push_back(rec(0, 0, 3, 4, 32'hAB));
    exp_q.push_back(rec(0, 0, 4, 5, 32'h44));
    step();
    idle();
    #1;
    chk("qry_j_stored_ready", 64'(qry_j_ready), 64'd1);
    chk("qry_j_stored_value", 64'(qry_j_value), 64'hAB);
    repeat (3) step();

    // drain entries 5..7
    rs_ready = 1'b1; rs_rob_id = 3'd5; rs_value = 32'h55;
    lsb_ready = 1'b1; lsb_rob_id = 3'd6; lsb_value = 32'h66;
    exp_q.push_back(rec(0, 0, 5, 6, 32'h55));
    exp_q.push_back(rec(0, 0, 6, 7, 32'h66));
    step();
    idle();
    rs_ready = 1'b1; rs_rob_id = 3'd7; rs_value = 32'h77;
    exp_q.push_back(rec(0, 0, 7, 8, 32'h77));
    step();
    idle();
    repeat (3) step();
    chk("drained_empty", 64'(rob_empty), 64'd1);
    chk("drained_alloc_id", 64'(alloc_id), 64'd0);

    // mispredicted branch at head flushes everything
    alloc(2'd1, 9, 32'h100);
    step();
    alloc(2'd0, 10, 32'd0);
    step();
    idle();
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h200;
    exp_q.push_back(rec(1, 0, 0, 0, 32'h200));
    step();
    idle();
    alloc(2'd0, 11, 32'd0);
    step();
    chk("mp_clear", 64'(clear), 64'd1);
    chk("mp_clear_pc", 64'(clear_pc), 64'h200);
    chk("mp_empty", 64'(rob_empty), 64'd1);
    chk("mp_alloc_dropped", 64'(alloc_id), 64'd0);
    step();
    chk("clear_one_pulse", 64'(clear), 64'd0);
    chk("clear_cycle_alloc_dropped", 64'(rob_empty), 64'd1);
    chk("clear_cycle_alloc_id", 64'(alloc_id), 64'd0);

    // store retire and correctly predicted branch
    alloc(2'd2, 7, 32'd0);
    step();
    alloc(2'd1, 9, 32'h300);
    step();
    idle();
    lsb_ready = 1'b1; lsb_rob_id = 3'd0; lsb_value = 32'h5;
    rs_ready = 1'b1; rs_rob_id = 3'd1; rs_value = 32'h300;
    exp_q.push_back(rec(0, 1, 0, 0, 32'h5));
    exp_q.push_back(rec(0, 0, 1, 0, 32'h300));
    step();
    idle();
    step();
    chk("store_commit", 64'(store_commit), 64'd1);
    repeat (2) step();
    chk("good_branch_empty", 64'(rob_empty), 64'd1);

    // steady stream: alloc and commit together every cycle, ids wrap
    b = 2;
    for (int i = 0; i < 22; i++) begin
      idle();
      if (i < 20) begin
        chk("wrap_alloc_id", 64'(alloc_id), 64'((b + i) % 8));
        alloc(2'd0, (i % 31) + 1, 32'd0);
      end
      if (i >= 1 && i <= 20) begin
        rs_ready = 1'b1; rs_rob_id = W'(b + i - 1); rs_value = 32'h1000 + 32'(i - 1);
        exp_q.push_back(rec(0, 0, (b + i - 1) % 8, ((i - 1) % 31) + 1, 32'h1000 + 32'(i - 1)));
      end
      step();
      if (i >= 2 && i < 20) begin
        d = alloc_id - commit_rob_id;
        chk("wrap_commit_valid", 64'(commit_valid), 64'd1);
        chk("wrap_occupancy", 64'(d), 64'd3);
      end
    end
    idle();
    repeat (2) step();
    chk("wrap_empty", 64'(rob_empty), 64'd1);

    // stall freezes state, then asynchronous reset mid-cycle
    alloc(2'd0, 3, 32'd0);
    step();
    alloc(2'd0, 4, 32'd0);
    rs_ready = 1'b1; rs_rob_id = 3'd6; rs_value = 32'h66;
    exp_q.push_back(rec(0, 0, 6, 3, 32'h66));
    step();
    idle();
    step();
    chk("pre_stall_commit", 64'(commit_valid), 64'd1);
    rdy_in = 1'b0;
    alloc(2'd0, 5, 32'd0);
    rs_ready = 1'b1; rs_rob_id = 3'd7; rs_value = 32'h77;
    step();
    chk("stall_alloc_id", 64'(alloc_id), 64'd0);
    chk("stall_commit_valid", 64'(commit_valid), 64'd0);
    chk("stall_commit_rd_hold", 64'(commit_rd), 64'd3);
    chk("stall_not_empty", 64'(rob_empty), 64'd0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_commit_rd", 64'(commit_rd), 64'd0);
    chk("arst_commit_value", 64'(commit_value), 64'd0);
    chk("arst_commit_id", 64'(commit_rob_id), 64'd0);
    chk("arst_clear_pc", 64'(clear_pc), 64'd0);
    chk("arst_empty", 64'(rob_empty), 64'd1);
    chk("arst_full", 64'(rob_full), 64'd0);
    chk("arst_alloc_id", 64'(alloc_id), 64'd0);
    idle();
    rdy_in = 1'b1;
    #2;
    rst_in = 1'b1;
    repeat (2) step();
    chk("final_empty", 64'(rob_empty), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer on the result side of the out-of-order core.
- Allocates the rob_id carried by every issued instruction.
- Receives the completion broadcasts produced by the ALU reservation station and the LSB, and answers operand-readiness queries from the decoder.
- Retires entries in program order to the register file and LSB, and raises the pipeline-wide clear on branch mispredict.

Parameters:
- ROB_WIDTH, 3, index width; ROB_SIZE = 2**ROB_WIDTH entries (default 8).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global stall; state frozen when low
- rob_full  out  1  count == ROB_SIZE (combinational)
- rob_empty  out  1  count == 0 (combinational)
- alloc_id  out  ROB_WIDTH  tail index, i.e. id the next allocation receives
- dec_ready  in  1  allocate one entry this cycle
- dec_kind  in  2  0 reg write, 1 branch, 2 store, 3 no writeback
- dec_rd  in  5  destination register
- dec_pred_pc  in  32  predicted next PC (branch only)
- qry_j_id, qry_k_id  in  ROB_WIDTH  operand dependency ids from decoder
- qry_j_ready, qry_k_ready  out  1  queried entry has its value
- qry_j_value, qry_k_value  out  32  that value
- rs_ready, rs_rob_id[ROB_WIDTH], rs_value[32]  in  ALU completion broadcast
- lsb_ready, lsb_rob_id[ROB_WIDTH], lsb_value[32]  in  LSB completion broadcast
- commit_valid  out  1  one-cycle retire pulse
- commit_rob_id  out  ROB_WIDTH  retired id
- commit_rd  out  5  retired destination; 0 for kinds 1/2/3
- commit_value  out  32  retired value
- store_commit  out  1  pulse: head store retired, LSB may write memory
- clear  out  1  one-cycle flush pulse
- clear_pc  out  32  redirect target

Behaviour:
- Storage and pointers:
  - Circular buffer; per entry: busy, ready, kind, rd, value, pred_pc.
  - head and tail are ROB_WIDTH bits and wrap naturally; count is ROB_WIDTH+1 bits.
- Reset:
  - busy/ready cleared, head = tail = count = 0.
  - All registered outputs 0; alloc_id 0, rob_empty 1, rob_full 0.
- rdy_in low:
  - No state change.
  - commit_valid, store_commit and clear are driven 0 next edge; other outputs hold.
- Allocation (rdy_in high):
  - dec_ready && !rob_full && !clear: entry[tail] becomes busy with ready=0; fields latched; tail++.
  - dec_ready while full is ignored; the decoder is contractually stalled.
- Completion:
  - Each valid broadcast whose id is busy and not ready sets value and ready=1.
  - rs and lsb with the same id in the same cycle: lsb wins (the decoder never produces this).
  - A broadcast to a non-busy entry is ignored.
  - A broadcast in the allocation cycle for the id being allocated is impossible and ignored.
- Query (combinational):
  - ready = (entry busy && ready) || (rs_ready && rs_rob_id == id) || (lsb_ready && lsb_rob_id == id).
  - value uses the same priority: lsb broadcast, then rs broadcast, then stored value.
- Commit:
  - At most one per cycle, when head is busy and ready.
  - Registered outputs are valid the cycle after the edge; latency from broadcast to commit_valid is at least 2 edges.
  - Store: store_commit=1 with commit_valid=1.
  - Branch with value == pred_pc: normal retire.
  - Branch with value != pred_pc: commit_valid=1, clear=1, clear_pc=value for one cycle. All entries invalidated; head = tail = count = 0 at that same edge. Allocation in that cycle is dropped.
- Count:
  - alloc only: +1; commit only: −1; both: unchanged.
  - Both when full: commit frees, alloc still blocked by the rob_full seen that cycle.
- An entry is never both allocated and committed in the same cycle; an empty buffer commits nothing.

Test Plan:
- Reset, then 8 allocations of kind 0 rd=1..8 → alloc_id 0..7 returned, rob_full=1 after the 8th. A 9th dec_ready is ignored; tail stays 0.
- Broadcast rs id 2 value 0x22 then id 0 value 0x10, lsb id 1 value 0x11 → commits ids 0,1,2 on consecutive cycles with rd 1,2,3 and values 0x10,0x11,0x22. No commit before id 0 is ready.
- Query qry_j_id=3 while rs broadcasts id 3 value 0xAB the same cycle → qry_j_ready=1, qry_j_value=0xAB combinationally.
- Branch at head with pred 0x100, rs value 0x200 → one clear pulse with clear_pc=0x200. rob_empty=1 next cycle; a dec_ready in the clear cycle is dropped.
- Wrap-around: run 20 alloc/commit pairs with a simultaneous alloc and commit every cycle → count constant, ids wrap 7→0, commit order matches allocation order.
- Async reset asserted mid-stream with rdy_in low → all outputs 0 immediately without a clock edge; rob_empty=1.
